// File: rtl/ul_reg_bank_mc.sv
// CPU register bank: version/scratch/LED/timeout/error registers and NUM_CH pipelined adders.
// Defining UL_REG_ERR_IRQ_EN adds the ul_irq output and a writable error mask.
module ul_reg_bank_mc #(
  parameter int          CPU_ADDR_WIDTH = 12,
  parameter int          CPU_DATA_WIDTH = 32,
  parameter int          NUM_CH         = 4,
  parameter int          ERR_WIDTH      = 8,
  parameter logic [31:0] VER_TIME       = 32'h2018_0308,
  parameter logic [31:0] VER_TYPE       = 32'h00D3_0010
) (
  input  logic                      clks,
  input  logic                      reset,
  input  logic                      cpu_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  input  logic                      cpu_rd,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
  output logic                      cpu_rd_vld,
  output logic [15:0]               ul2sh_vled,
  output logic [15:0]               reg_tmout_us_cfg,
`ifdef UL_REG_ERR_IRQ_EN
  output logic                      ul_irq,
`endif
  input  logic [ERR_WIDTH-1:0]      reg_tmout_us_err
);

  typedef logic [CPU_ADDR_WIDTH-1:0] addr_t;
  typedef logic [CPU_DATA_WIDTH-1:0] data_t;

  localparam addr_t A_VER_TIME = addr_t'(32'h0000_0000);
  localparam addr_t A_VER_TYPE = addr_t'(32'h0000_0001);
  localparam addr_t A_SCRATCH  = addr_t'(32'h0000_0002);
  localparam addr_t A_VLED     = addr_t'(32'h0000_0003);
  localparam addr_t A_TMOUT    = addr_t'(32'h0000_0004);
  localparam addr_t A_ERR      = addr_t'(32'h0000_0005);
  localparam addr_t A_MASK     = addr_t'(32'h0000_0006);
  localparam addr_t A_RDCNT    = addr_t'(32'h0000_0007);
  localparam addr_t A_OVF      = addr_t'(32'h0000_0008);
  localparam addr_t A_CH_BASE  = addr_t'(32'h0000_0010);
  localparam addr_t A_CH_NUM   = addr_t'(NUM_CH);

  data_t                 r_rd_data;
  logic                  r_rd_vld;
  data_t                 r_scratch;
  logic [15:0]           r_vled;
  logic [15:0]           r_tmout;
  logic [ERR_WIDTH-1:0]  r_err;
  logic [31:0]           r_rd_cnt;
  logic [NUM_CH-1:0]     r_ovf;

  addr_t                 w_ch_off;
  addr_t                 w_ch_idx;
  logic [1:0]            w_ch_reg;
  logic                  w_ch_hit;
  logic [NUM_CH-1:0]     w_ovf_set;
  data_t                 w_ch_val [NUM_CH];
  data_t                 w_ch_rd;
  data_t                 w_rd_data;
  logic [ERR_WIDTH-1:0]  w_mask;
  logic [ERR_WIDTH-1:0]  w_err_clr;
  logic [NUM_CH-1:0]     w_ovf_clr;
  logic                  w_wr_scr;
  logic                  w_wr_vled;
  logic                  w_wr_tmout;

  // Channel window starts at 0x010, four words per channel
  assign w_ch_off = cpu_wr_addr - A_CH_BASE;
  assign w_ch_idx = {2'b00, w_ch_off[CPU_ADDR_WIDTH-1:2]};
  assign w_ch_reg = w_ch_off[1:0];
  assign w_ch_hit = (cpu_wr_addr >= A_CH_BASE) && (w_ch_idx < A_CH_NUM);

  assign w_wr_scr   = cpu_wr && (cpu_wr_addr == A_SCRATCH);
  assign w_wr_vled  = cpu_wr && (cpu_wr_addr == A_VLED);
  assign w_wr_tmout = cpu_wr && (cpu_wr_addr == A_TMOUT);
  assign w_err_clr  = (cpu_wr && (cpu_wr_addr == A_ERR)) ? cpu_data_in[ERR_WIDTH-1:0]
                                                         : {ERR_WIDTH{1'b0}};
  assign w_ovf_clr  = (cpu_wr && (cpu_wr_addr == A_OVF)) ? cpu_data_in[NUM_CH-1:0]
                                                         : {NUM_CH{1'b0}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                    w_sel;
    logic [CPU_DATA_WIDTH:0] w_add;
    data_t                   r_opa;
    data_t                   r_opb;
    data_t                   r_sum;
    data_t                   r_s1_a;
    data_t                   r_s1_b;
    logic                    r_ctrl;
    logic                    r_s1_vld;
    logic                    r_s1_sat;

    assign w_sel         = cpu_wr && w_ch_hit && (w_ch_idx == addr_t'(c));
    assign w_add         = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_ovf_set[c]  = r_s1_vld & w_add[CPU_DATA_WIDTH];
    assign w_ch_val[c]   = (w_ch_reg == 2'd0) ? r_opa :
                           (w_ch_reg == 2'd1) ? r_opb :
                           (w_ch_reg == 2'd2) ? data_t'(r_ctrl) : r_sum;

    // Stage 1 latches the operand pair being written, stage 2 produces the sum
    always_ff @(posedge clks or posedge reset) begin
      if (reset) begin
        r_opa    <= {CPU_DATA_WIDTH{1'b0}};
        r_opb    <= {CPU_DATA_WIDTH{1'b0}};
        r_sum    <= {CPU_DATA_WIDTH{1'b0}};
        r_s1_a   <= {CPU_DATA_WIDTH{1'b0}};
        r_s1_b   <= {CPU_DATA_WIDTH{1'b0}};
        r_ctrl   <= 1'b0;
        r_s1_vld <= 1'b0;
        r_s1_sat <= 1'b0;
      end else begin
        r_s1_vld <= w_sel && !w_ch_reg[1];
        if (w_sel && (w_ch_reg == 2'd0)) begin
          r_opa    <= cpu_data_in;
          r_s1_a   <= cpu_data_in;
          r_s1_b   <= r_opb;
          r_s1_sat <= r_ctrl;
        end else if (w_sel && (w_ch_reg == 2'd1)) begin
          r_opb    <= cpu_data_in;
          r_s1_a   <= r_opa;
          r_s1_b   <= cpu_data_in;
          r_s1_sat <= r_ctrl;
        end else if (w_sel && (w_ch_reg == 2'd2)) begin
          r_ctrl   <= cpu_data_in[0];
        end
        if (r_s1_vld) begin
          r_sum <= (r_s1_sat && w_add[CPU_DATA_WIDTH]) ? {CPU_DATA_WIDTH{1'b1}}
                                                       : w_add[CPU_DATA_WIDTH-1:0];
        end
      end
    end
  end

  // Channel read data, zero when the address misses every channel
  always_comb begin
    w_ch_rd = {CPU_DATA_WIDTH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      w_ch_rd = w_ch_rd | ((w_ch_hit && (w_ch_idx == addr_t'(c))) ? w_ch_val[c]
                                                                  : {CPU_DATA_WIDTH{1'b0}});
    end
  end

  // Read mux from current register contents, so a same-cycle write is not visible
  always_comb begin
    w_rd_data = {CPU_DATA_WIDTH{1'b0}};
    case (cpu_wr_addr)
      A_VER_TIME: w_rd_data = data_t'(VER_TIME);
      A_VER_TYPE: w_rd_data = data_t'(VER_TYPE);
      A_SCRATCH:  w_rd_data = r_scratch;
      A_VLED:     w_rd_data = data_t'(r_vled);
      A_TMOUT:    w_rd_data = data_t'(r_tmout);
      A_ERR:      w_rd_data = data_t'(r_err);
      A_MASK:     w_rd_data = data_t'(w_mask);
      A_RDCNT:    w_rd_data = data_t'(r_rd_cnt);
      A_OVF:      w_rd_data = data_t'(r_ovf);
      default:    w_rd_data = w_ch_rd;
    endcase
  end

  // Global registers, sticky flags (set beats clear) and the registered read port
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      r_rd_data <= {CPU_DATA_WIDTH{1'b0}};
      r_rd_vld  <= 1'b0;
      r_scratch <= {CPU_DATA_WIDTH{1'b0}};
      r_vled    <= 16'h0000;
      r_tmout   <= 16'hFFFF;
      r_err     <= {ERR_WIDTH{1'b0}};
      r_rd_cnt  <= 32'h0000_0000;
      r_ovf     <= {NUM_CH{1'b0}};
    end else begin
      if (w_wr_scr)   r_scratch <= ~cpu_data_in;
      if (w_wr_vled)  r_vled    <= cpu_data_in[15:0];
      if (w_wr_tmout) r_tmout   <= cpu_data_in[15:0];
      r_err    <= (r_err & ~w_err_clr) | reg_tmout_us_err;
      r_ovf    <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
      r_rd_vld <= cpu_rd;
      if (cpu_rd) begin
        r_rd_data <= w_rd_data;
        r_rd_cnt  <= r_rd_cnt + 32'd1;
      end
    end
  end

`ifdef UL_REG_ERR_IRQ_EN
  logic [ERR_WIDTH-1:0] r_mask;
  logic                 r_irq;

  assign w_mask = r_mask;
  assign ul_irq = r_irq;

  // Error mask register and the masked-error interrupt
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      r_mask <= {ERR_WIDTH{1'b0}};
      r_irq  <= 1'b0;
    end else begin
      if (cpu_wr && (cpu_wr_addr == A_MASK)) r_mask <= cpu_data_in[ERR_WIDTH-1:0];
      r_irq <= |(r_err & ~r_mask);
    end
  end
`else
  assign w_mask = {ERR_WIDTH{1'b0}};
`endif

  assign cpu_data_out     = r_rd_data;
  assign cpu_rd_vld       = r_rd_vld;
  assign ul2sh_vled       = r_vled;
  assign reg_tmout_us_cfg = r_tmout;

endmodule

// File: tb/tb_ul_reg_bank_mc.sv
// Self-checking bench for ul_reg_bank_mc: directed steps followed by random traffic,
// all compared against a transaction-level model of the register map.
module tb_ul_reg_bank_mc;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int EW  = 8;

  logic          clks = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_wr = 1'b0;
  logic          cpu_rd = 1'b0;
  logic [AW-1:0] cpu_wr_addr = '0;
  logic [DW-1:0] cpu_data_in = '0;
  logic [EW-1:0] err_in = '0;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_rd_vld;
  logic [15:0]   ul2sh_vled;
  logic [15:0]   reg_tmout_us_cfg;
`ifdef UL_REG_ERR_IRQ_EN
  logic          ul_irq;
`endif

  int checks = 0;
  int errors = 0;

  ul_reg_bank_mc dut (
    .clks             (clks),
    .reset            (reset),
    .cpu_wr           (cpu_wr),
    .cpu_wr_addr      (cpu_wr_addr),
    .cpu_data_in      (cpu_data_in),
    .cpu_rd           (cpu_rd),
    .cpu_data_out     (cpu_data_out),
    .cpu_rd_vld       (cpu_rd_vld),
    .ul2sh_vled       (ul2sh_vled),
    .reg_tmout_us_cfg (reg_tmout_us_cfg),
`ifdef UL_REG_ERR_IRQ_EN
    .ul_irq           (ul_irq),
`endif
    .reg_tmout_us_err (err_in)
  );

  always #5 clks = ~clks;

  // Reference model: register values plus a queue of pending adder results
  typedef struct { int due; int ch; logic [31:0] a; logic [31:0] b; bit sat; } job_t;
  job_t          jobs[$];
  int            cyc = 0;
  logic [31:0]   m_scr, m_cnt, m_out;
  logic [15:0]   m_vled, m_tmout;
  logic [EW-1:0] m_err, m_mask;
  logic [NCH-1:0] m_ovf;
  logic [31:0]   m_opa [NCH];
  logic [31:0]   m_opb [NCH];
  logic [31:0]   m_sum [NCH];
  bit            m_ctrl [NCH];
  bit            m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_scr = 0; m_cnt = 0; m_out = 0; m_vled = 0; m_tmout = 16'hFFFF;
    m_err = 0; m_mask = 0; m_ovf = 0; m_irq = 0;
    for (int i = 0; i < NCH; i++) begin
      m_opa[i] = 0; m_opb[i] = 0; m_sum[i] = 0; m_ctrl[i] = 0;
    end
    jobs.delete();
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    int off;
    case (a)
      12'h000: return 32'h2018_0308;
      12'h001: return 32'h00D3_0010;
      12'h002: return m_scr;
      12'h003: return {16'h0, m_vled};
      12'h004: return {16'h0, m_tmout};
      12'h005: return {24'h0, m_err};
      12'h006: return {24'h0, m_mask};
      12'h007: return m_cnt;
      12'h008: return {28'h0, m_ovf};
      default: begin
        off = int'(a) - 16;
        if (off >= 0 && off < 4 * NCH) begin
          case (off % 4)
            0: return m_opa[off / 4];
            1: return m_opb[off / 4];
            2: return {31'h0, m_ctrl[off / 4]};
            default: return m_sum[off / 4];
          endcase
        end
        return 32'h0;
      end
    endcase
  endfunction

  // One bus cycle: drive inputs, advance the model, then check after the clock edge
  task automatic cycle(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input bit rd, input logic [EW-1:0] e);
    logic [32:0] s;
    logic [31:0] exp_rd;
    int off;
    job_t j;
    cpu_wr = wr; cpu_wr_addr = a; cpu_data_in = d; cpu_rd = rd; err_in = e;
    while (jobs.size() > 0 && jobs[0].due <= cyc) begin
      j = jobs.pop_front();
      s = {1'b0, j.a} + {1'b0, j.b};
      if (s[32]) m_ovf[j.ch] = 1'b1;
      m_sum[j.ch] = (s[32] && j.sat) ? 32'hFFFF_FFFF : s[31:0];
    end
    exp_rd = m_read(a);
    m_irq  = |(m_err & ~m_mask);
    if (wr) begin
      case (a)
        12'h002: m_scr = ~d;
        12'h003: m_vled = d[15:0];
        12'h004: m_tmout = d[15:0];
        12'h005: m_err = m_err & ~d[EW-1:0];
`ifdef UL_REG_ERR_IRQ_EN
        12'h006: m_mask = d[EW-1:0];
`endif
        12'h008: m_ovf = m_ovf & ~d[NCH-1:0];
        default: begin
          off = int'(a) - 16;
          if (off >= 0 && off < 4 * NCH) begin
            if (off % 4 == 0) m_opa[off / 4] = d;
            if (off % 4 == 1) m_opb[off / 4] = d;
            if (off % 4 == 2) m_ctrl[off / 4] = d[0];
            if (off % 4 < 2) jobs.push_back('{cyc + 2, off / 4, m_opa[off / 4], m_opb[off / 4], m_ctrl[off / 4]});
          end
        end
      endcase
    end
    m_err = m_err | e;
    if (rd) begin
      m_out = exp_rd;
      m_cnt = m_cnt + 32'd1;
    end
    @(posedge clks);
    #1;
    cyc++;
    check("rd_vld", 32'(cpu_rd_vld), 32'(rd));
    check(rd ? "rd_data" : "rd_hold", cpu_data_out, m_out);
    check("vled", 32'(ul2sh_vled), 32'(m_vled));
    check("tmout", 32'(reg_tmout_us_cfg), 32'(m_tmout));
`ifdef UL_REG_ERR_IRQ_EN
    check("irq", 32'(ul_irq), 32'(m_irq));
`endif
    cpu_wr = 1'b0; cpu_rd = 1'b0; err_in = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b0, a, 32'h0, 1'b1, '0);
  endtask

  task automatic idle();
    cycle(1'b0, 12'h000, 32'h0, 1'b0, '0);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    cpu_wr = 1'b0; cpu_rd = 1'b0; err_in = '0;
    reset = 1'b1;
    #3;
    model_reset();
    check("rst_dout", cpu_data_out, 32'h0);
    check("rst_vld", 32'(cpu_rd_vld), 32'h0);
    check("rst_vled", 32'(ul2sh_vled), 32'h0);
    check("rst_tmout", 32'(reg_tmout_us_cfg), 32'h0000_FFFF);
    reset = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            sel;
    model_reset();
    repeat (2) @(posedge clks);
    #1;
    do_reset();

    rd(12'h007); check("cnt0", cpu_data_out, 32'h0);
    rd(12'h007); check("cnt1", cpu_data_out, 32'h1);
    rd(12'h007); check("cnt2", cpu_data_out, 32'h2);
    rd(12'h000); check("ver_time", cpu_data_out, 32'h2018_0308);
    rd(12'h001); check("ver_type", cpu_data_out, 32'h00D3_0010);
    rd(12'h004); check("tmout_rst", cpu_data_out, 32'h0000_FFFF);

    wr(12'h002, 32'h1234_5678);
    rd(12'h002); check("scratch", cpu_data_out, 32'hEDCB_A987);
    wr(12'h7FF, 32'hDEAD_BEEF);
    rd(12'h7FF); check("unmapped", cpu_data_out, 32'h0);
    wr(12'h020, 32'hCAFE_F00D);
    rd(12'h020); check("ch_oor", cpu_data_out, 32'h0);
    cycle(1'b1, 12'h003, 32'hFFFF_A5A5, 1'b1, '0);
    check("rw_same", cpu_data_out, 32'h0);
    rd(12'h003); check("vled_rd", cpu_data_out, 32'h0000_A5A5);

    wr(12'h014, 32'hFFFF_FFF0);
    wr(12'h015, 32'h0000_0020);
    rd(12'h017); check("sum_early", cpu_data_out, 32'hFFFF_FFF0);
    rd(12'h017); check("sum_wrap", cpu_data_out, 32'h0000_0010);
    rd(12'h008); check("ovf1", cpu_data_out, 32'h0000_0002);
    wr(12'h016, 32'h0000_0001);
    wr(12'h015, 32'h0000_0020);
    idle();
    rd(12'h017); check("sum_sat", cpu_data_out, 32'hFFFF_FFFF);
    wr(12'h008, 32'h0000_0002);
    rd(12'h008); check("ovf_clr", cpu_data_out, 32'h0);

    cycle(1'b0, 12'h000, 32'h0, 1'b0, 8'h08);
    cycle(1'b1, 12'h005, 32'h0000_0008, 1'b0, 8'h08);
    rd(12'h005); check("err_setwin", cpu_data_out, 32'h0000_0008);
    wr(12'h005, 32'h0000_0008);
    rd(12'h005); check("err_clr", cpu_data_out, 32'h0);

    wr(12'h014, 32'h0000_0005);
    do_reset();
    idle(); idle(); idle();
    rd(12'h017); check("sum_rst", cpu_data_out, 32'h0);

`ifdef UL_REG_ERR_IRQ_EN
    cycle(1'b0, 12'h000, 32'h0, 1'b0, 8'h01);
    idle();
    check("irq_on", 32'(ul_irq), 32'h1);
    wr(12'h006, 32'h0000_0001);
    idle();
    check("irq_masked", 32'(ul_irq), 32'h0);
`else
    wr(12'h006, 32'h0000_00FF);
    rd(12'h006); check("mask_absent", cpu_data_out, 32'h0);
`endif

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 10);
      if (sel <= 8)      a = AW'(sel);
      else if (sel == 9) a = AW'(16 + $urandom_range(0, 4 * NCH + 3));
      else               a = AW'($urandom);
      d = ($urandom_range(0, 1) == 1) ? (32'hFFFF_0000 | 32'($urandom_range(0, 65535))) : $urandom;
      cycle(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? EW'($urandom) : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ul_reg_bank_mc.md
UL_REG_BANK_MC -- requirements
Module: ul_reg_bank_mc

Interface
REQ-001 Parameter CPU_ADDR_WIDTH, default 12, CPU address width.
REQ-002 Parameter CPU_DATA_WIDTH, default 32, CPU data width.
REQ-003 Parameter NUM_CH, default 4, legal 1..8, number of adder channels.
REQ-004 Parameter ERR_WIDTH, default 8, legal 1..32, error flag input width.
REQ-005 Parameters VER_TIME default 32'h2018_0308 and VER_TYPE default 32'h00D3_0010, version constants.
REQ-006 clks  in  1  clock; all logic SHALL be synchronous to its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cpu_wr  in  1  write strobe, one cycle per access.
REQ-009 cpu_wr_addr  in  CPU_ADDR_WIDTH  word address for both reads and writes.
REQ-010 cpu_data_in  in  CPU_DATA_WIDTH  write data.
REQ-011 cpu_rd  in  1  read strobe, one cycle per access.
REQ-012 cpu_data_out  out  CPU_DATA_WIDTH  registered read data.
REQ-013 cpu_rd_vld  out  1  read data valid.
REQ-014 ul2sh_vled  out  16  virtual LED register value.
REQ-015 reg_tmout_us_cfg  out  16  timeout configuration value.
REQ-016 reg_tmout_us_err  in  ERR_WIDTH  error event pulses.

Function
REQ-017 Address map: 0x000 VER_TIME RO; 0x001 VER_TYPE RO; 0x002 scratch; 0x003 vled RW [15:0]; 0x004 tmout cfg RW [15:0]; 0x005 err sticky W1C; 0x006 err mask RW; 0x007 read counter RO; 0x008 overflow sticky W1C [NUM_CH-1:0]; 0x010+4*c for c = 0..NUM_CH-1: opA RW, opB RW, ctrl RW [0], sum RO.
REQ-018 Read: cpu_rd in cycle N SHALL return data for cpu_wr_addr on cpu_data_out with cpu_rd_vld=1 in cycle N+1 only; cpu_data_out SHALL hold its value otherwise.
REQ-019 Unmapped or out-of-range channel address SHALL read 0; writes to it SHALL be ignored.
REQ-020 Write and read to the same address in the same cycle SHALL return the pre-write value.
REQ-021 Scratch SHALL read back the bitwise inverse of the last written value.
REQ-022 Read counter SHALL increment by 1 per cpu_rd, wrap 0xFFFF_FFFF to 0, and return its value sampled before the increment.
REQ-023 Err sticky bit i SHALL set when reg_tmout_us_err[i]=1; writing 1 SHALL clear it; set SHALL win over a simultaneous clear.
REQ-024 Channel c: writing opA or opB SHALL start a computation; sum SHALL update exactly 2 cycles after the write (two register stages).
REQ-025 ctrl[0]=0: sum = (opA+opB) mod 2^CPU_DATA_WIDTH; ctrl[0]=1: sum saturates to all-ones on carry out.
REQ-026 On carry out, overflow bit c SHALL set regardless of mode; clear via W1C; set SHALL win over a simultaneous clear.
REQ-027 Back-to-back operand writes SHALL pipeline; each produces its own sum 2 cycles later.
REQ-028 Unused upper bits of narrow registers SHALL read 0.

Reset
REQ-029 Reset SHALL clear all registers, cpu_data_out, cpu_rd_vld, counter, sticky bits, operands, sums and pipeline stages to 0, except tmout cfg, which resets to 16'hFFFF.
REQ-030 Reset asserted mid-computation SHALL discard in-flight results; no sum update after deassertion without a new write.

Configuration
REQ-031 With macro UL_REG_ERR_IRQ_EN defined: extra output ul_irq (1 bit); each cycle ul_irq SHALL be registered as OR(err_sticky & ~err_mask); reset value 0.
REQ-032 Without UL_REG_ERR_IRQ_EN: ul_irq SHALL be absent; err mask SHALL read 0 and ignore writes.

Verification
REQ-033 Reset, read 0x000, 0x001, 0x004 -> 0x2018_0308, 0x00D3_0010, 0x0000_FFFF, each with cpu_rd_vld 1 cycle after cpu_rd.
REQ-034 Write 0x002=0x1234_5678, then read -> 0xEDCB_A987; read 0x7FF -> 0.
REQ-035 Channel 1: opA=0xFFFF_FFF0, opB=0x20, ctrl=0 -> sum 0x10 after 2 cycles, overflow[1]=1; set ctrl=1 and rewrite opB -> sum 0xFFFF_FFFF.
REQ-036 Pulse err[3], write 0x005=0x08 in the same cycle as a second err[3] pulse -> bit 3 stays 1; later write 0x08 -> reads 0.
REQ-037 Three reads of 0x007 after reset -> 0, 1, 2; assert reset between opA write and sum update -> sum reads 0.
REQ-038 With UL_REG_ERR_IRQ_EN: err[0] pulse and mask=0 -> ul_irq=1; mask=1 -> ul_irq=0 next cycle.
